// File: rtl/sort_pkg.sv
// Shared definitions for the column top-K sorter and its feeder: default sizes,
// FSM state encoding and the flat-array slice convention.
package sort_pkg;

    localparam int DW_DEFAULT = 14;
    localparam int N_DEFAULT  = 40;
    localparam int K_DEFAULT  = 4;

    typedef enum logic {
        FILL = 1'b0,
        SORT = 1'b1
    } sort_state_e;

    // Entry i of a flat array lives at [i*dw +: dw].
    function automatic int slice_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/sort_feeder_if.sv
// Sample input stream and result output stream of the sorter front end.
// The master side is the environment (sample source / result sink), the slave side is the feeder.
interface sort_feeder_if import sort_pkg::*; #(
    parameter int DW = DW_DEFAULT,
    parameter int K  = K_DEFAULT
) ();

    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            res_valid;
    logic [K*DW-1:0] res_data;
    logic            res_ready;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/sort_result_slot.sv
// Single-entry valid/ready holding register for sorter results.
// A new capture wins over a consume in the same cycle.
module sort_result_slot import sort_pkg::*; #(
    parameter int W = DW_DEFAULT * K_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [W-1:0] cap_data,
    input  logic         res_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         slot_free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cap_data;
        end else if (valid_q && res_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Only feeds the feeder's next-state logic, never a registered output directly.
    assign slot_free = !valid_q || res_ready;
    assign res_valid = valid_q;
    assign res_data  = data_q;

endmodule

// File: rtl/sort_feeder.sv
// Packs N accepted samples into the sorter's flat input, runs the start/finish
// handshake with a timeout, and holds the K sorted results for downstream.
module sort_feeder import sort_pkg::*; #(
    parameter int DW  = DW_DEFAULT,
    parameter int N   = N_DEFAULT,
    parameter int K   = K_DEFAULT,
    parameter int TMO = 1024
) (
    input  logic            clk,
    input  logic            rst,
    sort_feeder_if.slave    bus,
    output logic [N*DW-1:0] data_flat,
    output logic            sort_start,
    input  logic            sort_finish,
    input  logic [K*DW-1:0] sorted_flat,
    output logic            busy,
    output logic            err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    sort_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [N*DW-1:0] data_flat_q, data_flat_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic            capture;
    logic            slot_free;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        data_flat_d = data_flat_q;
        start_d     = start_q;
        err_d       = err_q;
        capture     = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    data_flat_d[slice_lo(int'(cnt_q), DW) +: DW] = bus.in_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        tmo_d   = '0;
                        start_d = 1'b1;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SORT: begin
                // A finished sorter with a full, unconsumed slot stalls here without aging the timeout.
                if (sort_finish) begin
                    if (slot_free) begin
                        capture = 1'b1;
                        start_d = 1'b0;
                        tmo_d   = '0;
                        state_d = FILL;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    tmo_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            tmo_q       <= '0;
            data_flat_q <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            data_flat_q <= data_flat_d;
            start_q     <= start_d;
            err_q       <= err_d;
        end
    end

    sort_result_slot #(
        .W (K * DW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .cap_data  (sorted_flat),
        .res_ready (bus.res_ready),
        .res_valid (bus.res_valid),
        .res_data  (bus.res_data),
        .slot_free (slot_free)
    );

    assign bus.in_ready = (state_q == FILL);
    assign busy         = (state_q == SORT);
    assign sort_start   = start_q;
    assign err          = err_q;
    assign data_flat    = data_flat_q;

endmodule

// File: tb/tb_sort_feeder.sv
// Randomized bench for sort_feeder against a batch/queue level reference model,
// with a behavioural sorter that answers after a programmable latency.
module tb_sort_feeder;

    localparam int DW  = 14;
    localparam int N   = 40;
    localparam int K   = 4;
    localparam int TMO = 24;
    localparam int LAT = 20;

    typedef logic [N*DW-1:0] wide_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] data_flat;
    logic            sort_start;
    logic            sort_finish;
    logic [K*DW-1:0] sorted_flat;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    sort_feeder_if #(.DW(DW), .K(K)) bus ();

    sort_feeder #(
        .DW  (DW),
        .N   (N),
        .K   (K),
        .TMO (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .data_flat   (data_flat),
        .sort_start  (sort_start),
        .sort_finish (sort_finish),
        .sorted_flat (sorted_flat),
        .busy        (busy),
        .err         (err)
    );

    int checkCount = 0;
    int passCount  = 0;

    int              sorterLat = LAT;
    logic [K*DW-1:0] sorterResult;

    // Reference model: current batch as a queue, expected flat image, result slot and error flag.
    logic [DW-1:0]   batchQ[$];
    logic [N*DW-1:0] expFlat;
    bit              expSorting;
    int              waitCycles;
    bit              expResValid;
    logic [K*DW-1:0] expResData;
    bit              expErr;
    int              expCaptures = 0;

    task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic modelEdge();
        bit consumed;
        bit captured;
        if (rst) begin
            batchQ.delete();
            expFlat     = '0;
            expSorting  = 1'b0;
            waitCycles  = 0;
            expResValid = 1'b0;
            expResData  = '0;
            expErr      = 1'b0;
            return;
        end
        consumed = expResValid && bus.res_ready;
        captured = 1'b0;
        if (!expSorting) begin
            if (bus.in_valid) begin
                expFlat[batchQ.size()*DW +: DW] = bus.in_data;
                batchQ.push_back(bus.in_data);
                if (batchQ.size() == N) begin
                    batchQ.delete();
                    expSorting = 1'b1;
                    waitCycles = 0;
                end
            end
        end else if (sort_finish) begin
            if (!expResValid || bus.res_ready) begin
                captured   = 1'b1;
                expSorting = 1'b0;
            end
        end else begin
            waitCycles++;
            if (waitCycles == TMO) begin
                expErr     = 1'b1;
                expSorting = 1'b0;
            end
        end
        if (captured) begin
            expResValid = 1'b1;
            expResData  = sorted_flat;
            expCaptures++;
        end else if (consumed) begin
            expResValid = 1'b0;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("in_ready",   wide_t'(bus.in_ready),  wide_t'(!expSorting));
        checkOutput("sort_start", wide_t'(sort_start),    wide_t'(expSorting));
        checkOutput("busy",       wide_t'(busy),          wide_t'(expSorting));
        checkOutput("res_valid",  wide_t'(bus.res_valid), wide_t'(expResValid));
        checkOutput("res_data",   wide_t'(bus.res_data),  wide_t'(expResData));
        checkOutput("data_flat",  data_flat,              expFlat);
        checkOutput("err",        wide_t'(err),           wide_t'(expErr));
    endtask

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit rr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.res_ready = rr;
        stepCycle();
    endtask

    task automatic feedBatch(input int base, input bit randomData, input bit rr);
        for (int i = 0; i < N; i++)
            applyStimulus(1'b1, randomData ? DW'($urandom) : DW'(base + i), rr);
    endtask

    task automatic waitResult(input int limit);
        int startCaps;
        int n;
        startCaps = expCaptures;
        n = 0;
        while (expCaptures == startCaps && n < limit) begin
            applyStimulus(1'b0, DW'($urandom), 1'b1);
            n++;
        end
        checkOutput("result_seen", wide_t'(bus.res_valid), wide_t'(1));
    endtask

    // Behavioural sorter: finish after sorterLat start cycles (0 = never), held until start drops.
    initial begin
        int run;
        run = 0;
        sort_finish = 1'b0;
        sorted_flat = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!sort_start) begin
                sort_finish = 1'b0;
                run = 0;
            end else if (!sort_finish) begin
                run++;
                if (sorterLat > 0 && run >= sorterLat) begin
                    sort_finish = 1'b1;
                    sorted_flat = sorterResult;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [K*DW-1:0] firstResult;
        logic [K*DW-1:0] secondResult;
        firstResult  = {14'd597, 14'd598, 14'd599, 14'd800};
        secondResult = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};

        rst = 1'b1;
        sorterResult = firstResult;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, DW'(123), 1'b0);
        rst = 1'b0;
        $display("[TB] reset done");

        // Back-to-back batch 500..539 and a 20-cycle sorter.
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, DW'(500 + i), 1'b1);
        checkOutput("start_before_last", wide_t'(sort_start), wide_t'(0));
        applyStimulus(1'b1, DW'(539), 1'b1);
        checkOutput("entry0",           wide_t'(data_flat[0 +: DW]),      wide_t'(500));
        checkOutput("entry39",          wide_t'(data_flat[39*DW +: DW]),  wide_t'(539));
        checkOutput("start_after_last", wide_t'(sort_start),              wide_t'(1));
        checkOutput("ready_after_last", wide_t'(bus.in_ready),            wide_t'(0));
        waitResult(LAT + 10);
        checkOutput("first_result",     wide_t'(bus.res_data),  wide_t'(firstResult));
        checkOutput("start_dropped",    wide_t'(sort_start),    wide_t'(0));
        checkOutput("ready_back",       wide_t'(bus.in_ready),  wide_t'(1));

        // Backpressure: slot full, second batch finishes and must stall without timing out.
        $display("[TB] backpressure phase");
        sorterResult = secondResult;
        feedBatch(1000, 1'b0, 1'b0);
        for (int i = 0; i < LAT + TMO; i++) applyStimulus(1'b0, DW'($urandom), 1'b0);
        checkOutput("stall_start",  wide_t'(sort_start),    wide_t'(1));
        checkOutput("stall_busy",   wide_t'(busy),          wide_t'(1));
        checkOutput("stall_hold",   wide_t'(bus.res_data),  wide_t'(firstResult));
        checkOutput("stall_no_err", wide_t'(err),           wide_t'(0));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("swap_valid",   wide_t'(bus.res_valid), wide_t'(1));
        checkOutput("swap_data",    wide_t'(bus.res_data),  wide_t'(secondResult));
        applyStimulus(1'b0, '0, 1'b1);

        // Timeout: sorter never answers.
        $display("[TB] timeout phase");
        sorterLat = 0;
        feedBatch(0, 1'b1, 1'b1);
        repeat (TMO - 1) applyStimulus(1'b0, DW'($urandom), 1'b1);
        checkOutput("err_before_tmo",  wide_t'(err),          wide_t'(0));
        checkOutput("busy_before_tmo", wide_t'(busy),         wide_t'(1));
        applyStimulus(1'b0, DW'($urandom), 1'b1);
        checkOutput("err_at_tmo",      wide_t'(err),          wide_t'(1));
        checkOutput("start_at_tmo",    wide_t'(sort_start),   wide_t'(0));
        checkOutput("ready_at_tmo",    wide_t'(bus.in_ready), wide_t'(1));
        sorterLat = LAT;
        sorterResult = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
        feedBatch(0, 1'b1, 1'b1);
        waitResult(LAT + 10);
        checkOutput("err_sticky",      wide_t'(err),          wide_t'(1));
        checkOutput("post_tmo_result", wide_t'(bus.res_data), wide_t'(sorterResult));

        // Reset in the middle of a batch.
        $display("[TB] mid-batch reset phase");
        for (int i = 0; i < 25; i++) applyStimulus(1'b1, DW'(3000 + i), 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, DW'(4444), 1'b1);
        rst = 1'b0;
        checkOutput("rst_err_clear", wide_t'(err), wide_t'(0));
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, DW'(2000 + i), 1'b1);
        checkOutput("rst_no_early_start", wide_t'(sort_start), wide_t'(0));
        applyStimulus(1'b1, DW'(2039), 1'b1);
        checkOutput("rst_start",  wide_t'(sort_start),         wide_t'(1));
        checkOutput("rst_entry0", wide_t'(data_flat[0 +: DW]), wide_t'(2000));
        waitResult(LAT + 10);

        // Random valid gaps, random downstream readiness and sorter latency.
        $display("[TB] random phase");
        for (int c = 0; c < 900; c++) begin
            sorterLat    = int'($urandom_range(1, LAT));
            sorterResult = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 9) < 6));
        end
        checkOutput("random_batches", wide_t'(expCaptures > 6), wide_t'(1));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
